// File: rtl/card_draw_pkg.sv
// card_draw_pkg
//   Shared definitions for the card draw engine. It holds the per-card
//   animation states, the command opcodes, the fixed colours, and a helper
//   that places a card on the screen from its index.
package card_draw_pkg;

  typedef enum logic [2:0] {
    ST_DOWN      = 3'd0,
    ST_FLIP_UP   = 3'd1,
    ST_UP        = 3'd2,
    ST_FLIP_DOWN = 3'd3,
    ST_REMOVED   = 3'd4
  } cardState_t;

  localparam logic [1:0] OP_NOP       = 2'd0;
  localparam logic [1:0] OP_FLIP_UP   = 2'd1;
  localparam logic [1:0] OP_FLIP_DOWN = 2'd2;
  localparam logic [1:0] OP_REMOVE    = 2'd3;

  localparam logic [2:0] BACK     = 3'b001;  // card back interior
  localparam logic [2:0] BORDER   = 3'b111;  // 2-pixel frame on back and face
  localparam logic [2:0] HILITE   = 3'b110;  // cursor frame colour
  localparam logic [2:0] ZERO_SYM = 3'b110;  // symbol 0 would be black, so it is remapped

  typedef struct packed {
    int x0;
    int y0;
  } cardOrigin_t;

  // Top-left pixel of card idx in a row-major grid.
  function automatic cardOrigin_t cardOrigin(input int idx, input int gridCols,
                                             input int originX, input int originY,
                                             input int cardW, input int cardH,
                                             input int gap);
    cardOrigin_t o;
    o.x0 = originX + (idx % gridCols) * (cardW + gap);
    o.y0 = originY + (idx / gridCols) * (cardH + gap);
    return o;
  endfunction

endpackage

// File: rtl/card_draw_engine_fsm.sv
// card_flip_fsm
//   Animation state for one card: command accept, per-frame phase advance
//   and registered status flags.
//   Ports:
//     clk, reset   pixel clock, synchronous active-high reset
//     cmdHit       an accepted command targets this card this cycle
//     cmdOp        opcode of that command
//     frameStart   one pulse per frame; advances a running animation
//     cardState    current state
//     phase        animation phase, 0..FLIP_FRAMES-1
//     animating    registered: state is FLIP_UP or FLIP_DOWN
//     isUp         registered: state is UP
//     isRemoved    registered: state is REMOVED
module card_flip_fsm
  import card_draw_pkg::*;
#(
  parameter int FLIP_FRAMES = 8,
  localparam int PHW = $clog2(FLIP_FRAMES)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmdHit,
  input  logic [1:0]     cmdOp,
  input  logic           frameStart,
  output cardState_t     cardState,
  output logic [PHW-1:0] phase,
  output logic           animating,
  output logic           isUp,
  output logic           isRemoved
);

  localparam logic [PHW-1:0] LAST_PHASE = PHW'(FLIP_FRAMES - 1);

  cardState_t     stateNext;
  logic [PHW-1:0] phaseNext;

  // A command can only reach a card that is not animating, so giving the
  // command priority means a freshly started flip does not advance on the
  // frame_start it coincides with.
  always_comb begin
    stateNext = cardState;
    phaseNext = phase;
    if (cmdHit) begin
      case (cmdOp)
        OP_FLIP_UP: begin
          if (cardState == ST_DOWN) begin
            stateNext = ST_FLIP_UP;
            phaseNext = '0;
          end
        end
        OP_FLIP_DOWN: begin
          if (cardState == ST_UP) begin
            stateNext = ST_FLIP_DOWN;
            phaseNext = '0;
          end
        end
        OP_REMOVE: begin
          if (cardState == ST_DOWN || cardState == ST_UP) begin
            stateNext = ST_REMOVED;
          end
        end
        default: ;
      endcase
    end else if (frameStart && (cardState == ST_FLIP_UP || cardState == ST_FLIP_DOWN)) begin
      if (phase == LAST_PHASE) begin
        stateNext = (cardState == ST_FLIP_UP) ? ST_UP : ST_DOWN;
        phaseNext = '0;
      end else begin
        phaseNext = phase + PHW'(1);
      end
    end
  end

  // Status flags are loaded from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      cardState <= ST_DOWN;
      phase     <= '0;
      animating <= 1'b0;
      isUp      <= 1'b0;
      isRemoved <= 1'b0;
    end else begin
      cardState <= stateNext;
      phase     <= phaseNext;
      animating <= (stateNext == ST_FLIP_UP) || (stateNext == ST_FLIP_DOWN);
      isUp      <= (stateNext == ST_UP);
      isRemoved <= (stateNext == ST_REMOVED);
    end
  end

endmodule

// File: rtl/card_draw_engine.sv
// card_draw_engine
//   Draws an N_CARDS grid on the VGA raster and owns per-card flip/remove
//   animation state. Pixel colour comes out two clocks after HCount/VCount.
//   Ports:
//     clk, reset             pixel clock, synchronous active-high reset
//     HCount, VCount         raster position from the sync generator
//     pix_valid              visible-area flag aligned with HCount/VCount
//     frame_start            one pulse per frame, advances animations
//     symbols                4 bits per card, card i at [4i+3:4i]
//     cmd_valid/cmd_ready    command handshake (cmd_ready is combinational)
//     cmd_op, cmd_idx        command opcode and target card
//     busy                   some card is animating
//     face_up, removed       per-card status
//     rgb_valid, rgb         pixel output, latency 2
//   Build option CARD_HIGHLIGHT_EN adds cursor_idx/cursor_en: the border of
//   the cursor card is drawn in HILITE while cursor_en is high.
module card_draw_engine
  import card_draw_pkg::*;
#(
  parameter int         N_CARDS     = 16,
  parameter int         GRID_COLS   = 4,
  parameter int         ORIGIN_X    = 96,
  parameter int         ORIGIN_Y    = 80,
  parameter int         CARD_W      = 64,
  parameter int         CARD_H      = 80,
  parameter int         GAP         = 16,
  parameter int         FLIP_FRAMES = 8,
  parameter logic [2:0] BG_RGB      = 3'b000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             HCount,
  input  logic [9:0]             VCount,
  input  logic                   pix_valid,
  input  logic                   frame_start,
  input  logic [4*N_CARDS-1:0]   symbols,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [5:0]             cmd_idx,
  output logic                   busy,
  output logic [N_CARDS-1:0]     face_up,
  output logic [N_CARDS-1:0]     removed,
  output logic                   rgb_valid,
  output logic [2:0]             rgb
`ifdef CARD_HIGHLIGHT_EN
  ,
  input  logic [5:0]             cursor_idx,
  input  logic                   cursor_en
`endif
);

  localparam int IDXW = (N_CARDS > 1) ? $clog2(N_CARDS) : 1;
  localparam int PHW  = $clog2(FLIP_FRAMES);
  localparam int LXW  = $clog2(CARD_W);
  localparam int LYW  = $clog2(CARD_H);
  localparam int STEP = CARD_W / FLIP_FRAMES;

  // ---------------- per-card animation state ----------------
  cardState_t          cardStates [N_CARDS];
  logic [PHW-1:0]      cardPhases [N_CARDS];
  logic [N_CARDS-1:0]  animVec;
  logic [N_CARDS-1:0]  upVec;
  logic [N_CARDS-1:0]  remVec;
  logic [63:0]         animPad;
  logic                cmdAccept;

  // Padding to 64 lets any 6-bit index be looked up; indices past the
  // last card are rejected by the range compare anyway.
  assign animPad   = 64'(animVec);
  assign cmd_ready = (int'(cmd_idx) < N_CARDS) && !animPad[cmd_idx];
  assign cmdAccept = cmd_valid && cmd_ready;

  assign busy    = |animVec;
  assign face_up = upVec;
  assign removed = remVec;

  // ---------------- per-card hit test ----------------
  logic [N_CARDS-1:0] hit;
  logic [LXW-1:0]     lxCand [N_CARDS];
  logic [LYW-1:0]     lyCand [N_CARDS];
  logic [N_CARDS-1:0] unusedSymHi;  // symbol bit 3 does not affect colour

  genvar gi;
  generate
    for (gi = 0; gi < N_CARDS; gi++) begin : gCard
      localparam cardOrigin_t ORG =
        cardOrigin(gi, GRID_COLS, ORIGIN_X, ORIGIN_Y, CARD_W, CARD_H, GAP);

      card_flip_fsm #(.FLIP_FRAMES(FLIP_FRAMES)) uFsm (
        .clk        (clk),
        .reset      (reset),
        .cmdHit     (cmdAccept && (int'(cmd_idx) == gi)),
        .cmdOp      (cmd_op),
        .frameStart (frame_start),
        .cardState  (cardStates[gi]),
        .phase      (cardPhases[gi]),
        .animating  (animVec[gi]),
        .isUp       (upVec[gi]),
        .isRemoved  (remVec[gi])
      );

      assign hit[gi] = (int'(HCount) >= ORG.x0) && (int'(HCount) < ORG.x0 + CARD_W) &&
                       (int'(VCount) >= ORG.y0) && (int'(VCount) < ORG.y0 + CARD_H);
      assign lxCand[gi]      = LXW'(int'(HCount) - ORG.x0);
      assign lyCand[gi]      = LYW'(int'(VCount) - ORG.y0);
      assign unusedSymHi[gi] = symbols[4*gi+3];
    end
  endgenerate

  // ---------------- stage 1: select the hit card ----------------
  // Cards never overlap, so at most one hit bit is set.
  logic            hitAny;
  logic [IDXW-1:0] hitIdx;
  logic [LXW-1:0]  lxSel;
  logic [LYW-1:0]  lySel;
  logic [2:0]      symSel;

  always_comb begin
    hitAny = 1'b0;
    hitIdx = '0;
    lxSel  = '0;
    lySel  = '0;
    symSel = '0;
    for (int i = 0; i < N_CARDS; i++) begin
      if (hit[i]) begin
        hitAny = 1'b1;
        hitIdx = IDXW'(i);
        lxSel  = lxCand[i];
        lySel  = lyCand[i];
        symSel = symbols[4*i +: 3];
      end
    end
  end

  logic            hitValidReg;
  logic [IDXW-1:0] hitIdxReg;
  logic [LXW-1:0]  lxReg;
  logic [LYW-1:0]  lyReg;
  logic [2:0]      symReg;
  logic            pixValidReg;
`ifdef CARD_HIGHLIGHT_EN
  logic            hiliteReg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hitValidReg <= 1'b0;
      hitIdxReg   <= '0;
      lxReg       <= '0;
      lyReg       <= '0;
      symReg      <= '0;
      pixValidReg <= 1'b0;
`ifdef CARD_HIGHLIGHT_EN
      hiliteReg   <= 1'b0;
`endif
    end else begin
      hitValidReg <= hitAny;
      hitIdxReg   <= hitIdx;
      lxReg       <= lxSel;
      lyReg       <= lySel;
      symReg      <= symSel;
      pixValidReg <= pix_valid;
`ifdef CARD_HIGHLIGHT_EN
      hiliteReg   <= cursor_en && hitAny && (int'(cursor_idx) == int'(hitIdx));
`endif
    end
  end

  // ---------------- stage 2: colour ----------------
  cardState_t curState;
  int         curPhase;
  int         foldPhase;
  int         inset;
  int         lxI;
  int         lyI;
  logic       showFace;
  logic       onBorder;
  logic       drawn;
  logic [2:0] borderColour;
  logic [2:0] faceColour;
  logic [2:0] colour;
  logic [2:0] rgbNext;

  always_comb begin
    curState  = cardStates[hitIdxReg];
    curPhase  = int'(cardPhases[hitIdxReg]);
    lxI       = int'(lxReg);
    lyI       = int'(lyReg);
    // Width shrinks towards mid-flip and grows back: inset is symmetric in phase.
    foldPhase = (curPhase < FLIP_FRAMES - 1 - curPhase) ? curPhase
                                                        : FLIP_FRAMES - 1 - curPhase;
    inset     = 0;
    showFace  = 1'b0;
    case (curState)
      ST_UP: showFace = 1'b1;
      ST_FLIP_UP: begin
        showFace = (curPhase >= FLIP_FRAMES / 2);
        inset    = STEP * foldPhase;
      end
      ST_FLIP_DOWN: begin
        showFace = (curPhase < FLIP_FRAMES / 2);
        inset    = STEP * foldPhase;
      end
      default: showFace = 1'b0;
    endcase

    onBorder = (lxI < 2) || (lxI >= CARD_W - 2) || (lyI < 2) || (lyI >= CARD_H - 2);
    drawn    = hitValidReg && (curState != ST_REMOVED) &&
               (lxI >= inset) && (lxI <= CARD_W - 1 - inset);

`ifdef CARD_HIGHLIGHT_EN
    borderColour = hiliteReg ? HILITE : BORDER;
`else
    borderColour = BORDER;
`endif
    faceColour = (symReg == 3'b000) ? ZERO_SYM : symReg;

    if (!drawn)        colour = BG_RGB;
    else if (onBorder) colour = borderColour;
    else if (showFace) colour = faceColour;
    else               colour = BACK;

    rgbNext = pixValidReg ? colour : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= 3'b000;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= rgbNext;
      rgb_valid <= pixValidReg;
    end
  end

endmodule

// File: tb/tb_card_draw_engine.sv
// tb_card_draw_engine
//   Self-checking bench for card_draw_engine with default parameters:
//   a table of pixel vectors after reset, hand-written animation sequences,
//   and randomized commands/pixels checked against a reference model.
module tb_card_draw_engine;

  localparam int N = 16;
  localparam int M_DOWN = 0, M_FU = 1, M_UP = 2, M_FD = 3, M_REM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  HCount = '0;
  logic [9:0]  VCount = '0;
  logic        pix_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [63:0] symbols = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [5:0]  cmd_idx = '0;
  logic        busy;
  logic [15:0] face_up;
  logic [15:0] removed;
  logic        rgb_valid;
  logic [2:0]  rgb;

  always #5 clk = ~clk;

  card_draw_engine dut (
    .clk         (clk),
    .reset       (reset),
    .HCount      (HCount),
    .VCount      (VCount),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .symbols     (symbols),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_idx     (cmd_idx),
    .busy        (busy),
    .face_up     (face_up),
    .removed     (removed),
    .rgb_valid   (rgb_valid),
    .rgb         (rgb)
`ifdef CARD_HIGHLIGHT_EN
    ,
    .cursor_idx  (6'd0),
    .cursor_en   (1'b0)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: card states and phases as plain integers.
  int mState [N];
  int mPhase [N];

  int expRgbQ [$];
  int expValQ [$];
  int tagHQ   [$];
  int tagVQ   [$];

  typedef struct {
    int         h;
    int         v;
    logic       pv;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mAnim(input int c);
    return (mState[c] == M_FU) || (mState[c] == M_FD);
  endfunction

  function automatic bit mReady(input int idx);
    if (idx >= N) return 1'b0;
    return !mAnim(idx);
  endfunction

  function automatic int mBusy();
    for (int c = 0; c < N; c++) if (mAnim(c)) return 1;
    return 0;
  endfunction

  function automatic int mFaceVec();
    int r = 0;
    for (int c = 0; c < N; c++) if (mState[c] == M_UP) r |= (1 << c);
    return r;
  endfunction

  function automatic int mRemVec();
    int r = 0;
    for (int c = 0; c < N; c++) if (mState[c] == M_REM) r |= (1 << c);
    return r;
  endfunction

  // Colour the screen would show at (h,v) for the current model state.
  function automatic logic [2:0] modelPixel(input int h, input int v);
    for (int c = 0; c < N; c++) begin
      int x0 = 96 + (c % 4) * 80;
      int y0 = 80 + (c / 4) * 96;
      if (h >= x0 && h < x0 + 64 && v >= y0 && v < y0 + 80) begin
        int lx = h - x0;
        int ly = v - y0;
        int inset = 0;
        int ph = mPhase[c];
        bit face = 1'b0;
        logic [2:0] s;
        if (mState[c] == M_REM) return 3'b000;
        if (mAnim(c)) inset = 8 * ((ph < 7 - ph) ? ph : 7 - ph);
        if (lx < inset || lx > 63 - inset) return 3'b000;
        if (mState[c] == M_UP) face = 1'b1;
        if (mState[c] == M_FU && ph >= 4) face = 1'b1;
        if (mState[c] == M_FD && ph < 4) face = 1'b1;
        if (lx < 2 || lx > 61 || ly < 2 || ly > 77) return 3'b111;
        if (!face) return 3'b001;
        s = symbols[4*c +: 3];
        return (s == 3'b000) ? 3'b110 : s;
      end
    end
    return 3'b000;
  endfunction

  // One clock: check the combinational ready, clock, advance the model,
  // then check the registered status outputs.
  task automatic step();
    bit acc;
    int idx;
    #1;
    idx = int'(cmd_idx);
    check("cmd_ready", int'(cmd_ready), int'(mReady(idx)));
    acc = cmd_valid && mReady(idx);
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (reset) begin
        mState[c] = M_DOWN;
        mPhase[c] = 0;
      end else if (acc && c == idx) begin
        case (cmd_op)
          2'd1: if (mState[c] == M_DOWN) begin mState[c] = M_FU; mPhase[c] = 0; end
          2'd2: if (mState[c] == M_UP) begin mState[c] = M_FD; mPhase[c] = 0; end
          2'd3: if (mState[c] == M_DOWN || mState[c] == M_UP) mState[c] = M_REM;
          default: ;
        endcase
      end else if (frame_start && mAnim(c)) begin
        if (mPhase[c] == 7) begin
          mState[c] = (mState[c] == M_FU) ? M_UP : M_DOWN;
          mPhase[c] = 0;
        end else begin
          mPhase[c]++;
        end
      end
    end
    check("busy", int'(busy), mBusy());
    check("face_up", int'(face_up), mFaceVec());
    check("removed", int'(removed), mRemVec());
  endtask

  // Present one pixel; the result of the previous one is compared after the
  // clock, which together gives the two-cycle latency.
  task automatic pix(input int h, input int v, input logic pv, input logic [2:0] exp);
    HCount    = 10'(h);
    VCount    = 10'(v);
    pix_valid = pv;
    expRgbQ.push_back(int'(exp));
    expValQ.push_back(int'(pv));
    tagHQ.push_back(h);
    tagVQ.push_back(v);
    step();
    if (expRgbQ.size() == 2) begin
      int e  = expRgbQ.pop_front();
      int ev = expValQ.pop_front();
      int th = tagHQ.pop_front();
      int tv = tagVQ.pop_front();
      check($sformatf("rgb@%0d,%0d", th, tv), int'(rgb), e);
      check($sformatf("rgb_valid@%0d,%0d", th, tv), int'(rgb_valid), ev);
    end
  endtask

  task automatic flush();
    pix(0, 0, 1'b0, 3'b000);
    expRgbQ.delete();
    expValQ.delete();
    tagHQ.delete();
    tagVQ.delete();
    pix_valid = 1'b0;
  endtask

  task automatic cmd(input logic [1:0] op, input int idx);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = 6'(idx);
    step();
    cmd_valid = 1'b0;
    $display("cmd op=%0d idx=%0d busy=%0d face_up=%h removed=%h", op, idx, busy, face_up, removed);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      mState[c] = M_DOWN;
      mPhase[c] = 0;
    end

    // Card 0 spans x 96..159, y 80..159; card 15 spans x 336..399, y 368..447.
    tbl[0]  = '{h: 96,  v: 80,  pv: 1'b1, exp: 3'b111};
    tbl[1]  = '{h: 106, v: 90,  pv: 1'b1, exp: 3'b001};
    tbl[2]  = '{h: 97,  v: 81,  pv: 1'b1, exp: 3'b111};
    tbl[3]  = '{h: 98,  v: 82,  pv: 1'b1, exp: 3'b001};
    tbl[4]  = '{h: 159, v: 100, pv: 1'b1, exp: 3'b111};
    tbl[5]  = '{h: 160, v: 100, pv: 1'b1, exp: 3'b000};
    tbl[6]  = '{h: 400, v: 400, pv: 1'b1, exp: 3'b000};
    tbl[7]  = '{h: 399, v: 447, pv: 1'b1, exp: 3'b111};
    tbl[8]  = '{h: 106, v: 90,  pv: 1'b0, exp: 3'b000};
    tbl[9]  = '{h: 200, v: 170, pv: 1'b1, exp: 3'b000};
    tbl[10] = '{h: 0,   v: 0,   pv: 1'b1, exp: 3'b000};
    tbl[11] = '{h: 350, v: 400, pv: 1'b1, exp: 3'b001};

    // Initial reset without checks: outputs are undefined before it.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    doReset();
    check("reset_busy", int'(busy), 0);
    check("reset_face_up", int'(face_up), 0);
    check("reset_removed", int'(removed), 0);
    check("reset_rgb", int'(rgb), 0);
    check("reset_rgb_valid", int'(rgb_valid), 0);
    $display("reset done");

    // ---- table of pixels with every card face down ----
    for (int i = 0; i < 12; i++) begin
      pix(tbl[i].h, tbl[i].v, tbl[i].pv, tbl[i].exp);
      $display("vec %0d h=%0d v=%0d pv=%0d expect=%0d", i, tbl[i].h, tbl[i].v, tbl[i].pv, tbl[i].exp);
    end
    flush();

    // ---- latency and out-of-range index ----
    HCount = 10'd0; VCount = 10'd0; pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    check("lat_cycle1", int'(rgb_valid), 0);
    step();
    check("lat_cycle2", int'(rgb_valid), 1);
    step();
    check("lat_cycle3", int'(rgb_valid), 0);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_idx = 6'd16;
    #1;
    check("ready_idx_n", int'(cmd_ready), 0);
    step();
    cmd_valid = 1'b0;
    check("idx_n_no_effect", int'(busy), 0);
    $display("latency / range sequence done");

    // ---- reset in the middle of a flip ----
    cmd(2'd1, 3);
    frame();
    frame();
    check("midflip_busy", int'(busy), 1);
    HCount = 10'd346; VCount = 10'd90; pix_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    pix_valid = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_face", int'(face_up), 0);
    check("rst_mid_rgb", int'(rgb), 0);
    check("rst_mid_rgb_valid", int'(rgb_valid), 0);
    step();
    check("rst_mid_rgb_next", int'(rgb), 0);
    pix(346, 90, 1'b1, 3'b001);
    flush();
    $display("reset mid-flip sequence done");

    // ---- full flip of card 0 with inset and busy-card checks ----
    symbols        = '0;
    symbols[3:0]   = 4'h5;
    symbols[23:20] = 4'h0;
    cmd(2'd1, 0);
    check("flip0_busy_start", int'(busy), 1);
    frame();
    frame();
    pix(111, 90, 1'b1, 3'b000);
    pix(112, 90, 1'b1, 3'b001);
    flush();
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_idx = 6'd0;
    #1;
    check("ready_busy_card0", int'(cmd_ready), 0);
    cmd_idx = 6'd1;
    #1;
    check("ready_idle_card1", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      frame();
      check($sformatf("flip0_busy_f%0d", k), int'(busy), (k < 8) ? 1 : 0);
      check($sformatf("flip0_face_f%0d", k), int'(face_up[0]), (k == 8) ? 1 : 0);
    end
    pix(106, 90, 1'b1, 3'd5);
    flush();
    $display("flip card 0 sequence done");

    // ---- remove a face-up card 5 ----
    cmd(2'd1, 5);
    repeat (8) frame();
    check("c5_up", int'(face_up[5]), 1);
    pix(186, 186, 1'b1, 3'b110);
    flush();
    cmd(2'd3, 5);
    check("c5_removed", int'(removed[5]), 1);
    check("c5_not_up", int'(face_up[5]), 0);
    pix(176, 176, 1'b1, 3'b000);
    pix(200, 200, 1'b1, 3'b000);
    pix(239, 255, 1'b1, 3'b000);
    flush();
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_idx = 6'd5;
    #1;
    check("c5_ready_after_remove", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    check("c5_still_removed", int'(removed[5]), 1);
    check("c5_no_anim", int'(busy), 0);
    $display("remove card 5 sequence done");

    // ---- randomized commands and pixels against the model ----
    doReset();
    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < 30; i++) begin
        cmd_valid   = ($urandom % 2) == 0;
        cmd_op      = 2'($urandom % 4);
        cmd_idx     = 6'($urandom_range(0, 17));
        frame_start = ($urandom % 3) == 0;
        if (cmd_valid && mReady(int'(cmd_idx)))
          $display("rnd cmd op=%0d idx=%0d frame=%0d", cmd_op, cmd_idx, frame_start);
        step();
      end
      cmd_valid   = 1'b0;
      frame_start = 1'b0;
      for (int i = 0; i < 30; i++) begin
        int h = $urandom_range(80, 420);
        int v = $urandom_range(60, 470);
        logic pv = ($urandom % 10) != 0;
        symbols = {$urandom, $urandom};
        pix(h, v, pv, pv ? modelPixel(h, v) : 3'b000);
      end
      flush();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_draw_engine.md
Name: card_draw_engine

Overview:
- Parametrised successor to the fixed 16-card renderer: draws an N-card grid on the VGA raster and owns per-card flip and remove animation state.
- Takes HCount/VCount from the sync generator and card commands from the game controller.
- Outputs a registered 3-bit rgb with fixed pipeline latency.
- Sits between the VGA timing block and the DAC/pin outputs.

Parameters:
- N_CARDS, 16, number of cards; 1..64.
- GRID_COLS, 4, cards per row; row = idx / GRID_COLS, col = idx % GRID_COLS.
- ORIGIN_X, 96, pixel x of card 0 left edge.
- ORIGIN_Y, 80, pixel y of card 0 top edge.
- CARD_W, 64, card width in pixels; multiple of FLIP_FRAMES.
- CARD_H, 80, card height in pixels.
- GAP, 16, pixels between adjacent cards, both axes.
- FLIP_FRAMES, 8, frames per flip animation; power of two, ≥ 2.
- BG_RGB, 3'b000, background colour.

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- HCount  in  10  current pixel x
- VCount  in  10  current pixel y
- pix_valid  in  1  visible-area flag aligned with HCount/VCount
- frame_start  in  1  one-cycle pulse per frame, during vertical blank
- symbols  in  4*N_CARDS  per-card symbol; card i uses bits [4i+3:4i]
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted this cycle when high with cmd_valid
- cmd_op  in  2  0 NOP, 1 FLIP_UP, 2 FLIP_DOWN, 3 REMOVE
- cmd_idx  in  6  target card index
- busy  out  1  any card is animating
- face_up  out  N_CARDS  card is stable FACE_UP
- removed  out  N_CARDS  card is REMOVED
- rgb_valid  out  1  pix_valid delayed by 2
- rgb  out  3  pixel colour, latency 2

Behaviour:
- Reset, synchronous: every card goes to DOWN with phase 0. busy=0, face_up=0, removed=0, rgb=0, rgb_valid=0, pipeline registers cleared. An animation in progress is abandoned.
- Per-card states: DOWN, FLIP_UP, UP, FLIP_DOWN, REMOVED.
- cmd_ready is combinational. It is 0 when cmd_idx ≥ N_CARDS or the target card is in FLIP_UP/FLIP_DOWN; otherwise 1.
- Accepted command (cmd_valid & cmd_ready):
  - FLIP_UP on DOWN → FLIP_UP, phase=0.
  - FLIP_DOWN on UP → FLIP_DOWN, phase=0.
  - REMOVE on DOWN or UP → REMOVED.
  - Any other op/state combination is accepted and is a no-op.
  - Transition takes effect on the next clk edge.
- Animation: on a frame_start pulse, each animating card increments phase. When phase = FLIP_FRAMES-1 and frame_start arrives, FLIP_UP → UP, FLIP_DOWN → DOWN, phase → 0.
- If a command and frame_start hit the same card in the same cycle, the command wins. The newly started animation does not advance that cycle.
- busy = OR of animating cards. face_up[i] = (state==UP). removed[i] = (state==REMOVED). All three are registered.
- Geometry: card i covers x0 ≤ HCount < x0+CARD_W and y0 ≤ VCount < y0+CARD_H, where x0 = ORIGIN_X + col*(CARD_W+GAP) and y0 = ORIGIN_Y + row*(CARD_H+GAP). Cards never overlap; the hit select is one-hot or zero.
- Flip inset: STEP = CARD_W/FLIP_FRAMES, inset = STEP*min(phase, FLIP_FRAMES-1-phase). Only lx in [inset, CARD_W-1-inset] is drawn, where lx = HCount-x0; the rest of the card area shows BG_RGB.
  - During FLIP_UP, phase < FLIP_FRAMES/2 shows the back; later phases show the face.
  - FLIP_DOWN is the mirror of FLIP_UP.
- Colours:
  - Back: 3'b001 interior, 3'b111 for the 2-pixel border.
  - Face: 3'b111 border, interior = symbol[2:0], with 0 mapped to 3'b110.
  - REMOVED card area and outside all cards: BG_RGB.
- Pipeline: stage 1 registers hit index, lx, ly and pix_valid. Stage 2 registers rgb and rgb_valid. rgb = 0 whenever the delayed pix_valid is 0.
- symbols is sampled in stage 1 and may change at any time.

Optional Feature:
- Macro CARD_HIGHLIGHT_EN.
- When defined, two ports are added: cursor_idx (in, 6) and cursor_en (in, 1). While cursor_en=1, the border of card cursor_idx is drawn 3'b110 in any non-REMOVED state. Pipeline latency is unchanged.
- When undefined, the ports are absent and borders follow the normal colour rules.

Decomposition:
- Package card_draw_pkg: card state enum, cmd_op encodings, colour constants (BACK, BORDER, HILITE, ZERO_SYM), and a function computing x0/y0 from the index.
- Sub-module card_flip_fsm, instantiated N_CARDS times via generate. It contains state, phase counter, command accept and frame advance. It outputs state, phase and status bits.

Test Plan:
- Reset mid-flip: FLIP_UP card 3, two frame_starts, then reset → card 3 DOWN, busy=0, rgb=0 on the next cycle.
- FLIP_UP card 0, then 8 frame_starts → busy=1 for frames 0..7, face_up[0]=1 after the 8th, and pixel (ORIGIN_X+10, ORIGIN_Y+10) = symbol[2:0] two cycles after presentation.
- Phase 2 of FLIP_UP: pixel at lx = 2*8-1 → BG_RGB, pixel at lx = 16 → back colour 3'b001.
- Command to a busy card: cmd_valid for card 0 while it flips → cmd_ready=0. Command to card 1 in the same cycle → accepted.
- REMOVE on UP card 5 → removed[5]=1 and its whole area = BG_RGB. A later FLIP_UP to card 5 is accepted with no change.
- Latency: pix_valid pulse at HCount=0 → rgb_valid high exactly 2 cycles later. cmd_idx=N_CARDS → cmd_ready=0.
